// File: rtl/avg_arb_pkg.sv
// rtl/avg_arb_pkg.sv - shared defaults, width helper and FSM state type for the averaging arbiter
package avg_arb_pkg;

  localparam int W_DEFAULT = 28;

  // Index width for a value range; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/avg_arb_sched_if.sv
// rtl/avg_arb_sched_if.sv - request/result handshake bundle for avg_arb_sched
interface avg_arb_sched_if
  import avg_arb_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int N_CH = 4
);
  localparam int CW = clog2(N_CH);

  logic [N_CH-1:0]   req_valid;
  logic [N_CH*W-1:0] req_data;
  logic [N_CH-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_chan;
  logic [W-1:0]      out_data;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_chan, out_data
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_chan, out_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, search starts after the last granted channel
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int PW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] grant
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk channels ptr+1 .. ptr+N_CH (wrapping) and grant the first requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = PW'((int'(ptr) + i) % N_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avg_arb_sched.sv
// rtl/avg_arb_sched.sv - round-robin sampler with per-channel block averaging; AVG_ARB_SCHED_ROUND_EN selects round-half-up
module avg_arb_sched
  import avg_arb_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int N_CH  = 4,
  parameter int N_AVG = 1024
) (
  input  logic          clock_in,
  input  logic          reset,
  input  logic          enable,
  avg_arb_sched_if.slave bus
);

  localparam int CW = clog2(N_CH);
  localparam int LA = clog2(N_AVG);
  localparam int AW = W + LA;

  state_t                state, state_nxt;
  logic [CW-1:0]         ptr;
  logic [CW-1:0]         gidx;
  logic [N_CH-1:0]       arb_req;
  logic [N_CH-1:0]       grant;
  logic                  stall;
  logic                  fire;
  logic                  done;
  logic signed [W-1:0]   samples [N_CH];
  logic signed [W-1:0]   sample;
  logic signed [AW-1:0]  acc [N_CH];
  logic [LA-1:0]         cnt [N_CH];
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  rounded;
  logic [W-1:0]          data_q;
  logic [CW-1:0]         chan_q;

  // A pending result that downstream is not taking blocks all new samples.
  assign stall   = (state == ST_HOLD) && !bus.out_ready;
  assign arb_req = (enable && !stall) ? bus.req_valid : '0;

  rr_arbiter #(.N_CH(N_CH), .PW(CW)) u_arb (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign fire          = |grant;

  for (genvar g = 0; g < N_CH; g++) begin : g_split
    assign samples[g] = bus.req_data[g*W +: W];
  end

  // Encode the one-hot grant into the channel index used for all per-channel state.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) gidx = CW'(i);
    end
  end

  assign sample = samples[gidx];
  assign sum    = acc[gidx] + {{LA{sample[W-1]}}, sample};
  assign done   = fire && (cnt[gidx] == LA'(N_AVG - 1));

`ifdef AVG_ARB_SCHED_ROUND_EN
  assign rounded = sum + AW'(N_AVG / 2);
`else
  assign rounded = sum;
`endif

  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_chan  = chan_q;
  assign bus.out_data  = data_q;

  // Control state register.
  always_ff @(posedge clock_in) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // HOLD persists until out_ready; a block completion always lands in HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD: begin
        if (bus.out_ready) state_nxt = done ? ST_HOLD : (fire ? ST_ACCUM : ST_IDLE);
      end
      default: state_nxt = done ? ST_HOLD : (fire ? ST_ACCUM : ST_IDLE);
    endcase
  end

  // Per-channel accumulation, pointer advance and result capture on each transfer.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      ptr    <= CW'(N_CH - 1);
      data_q <= '0;
      chan_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (fire) begin
      ptr <= gidx;
      if (done) begin
        acc[gidx] <= '0;
        cnt[gidx] <= '0;
        data_q    <= W'(rounded >>> LA);
        chan_q    <= gidx;
      end else begin
        acc[gidx] <= sum;
        cnt[gidx] <= cnt[gidx] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avg_arb_sched.sv
// tb/tb_avg_arb_sched.sv - randomized and directed scoreboard bench for avg_arb_sched
module tb_avg_arb_sched;

  localparam int W     = 28;
  localparam int N_CH  = 4;
  localparam int N_AVG = 4;

  typedef struct {
    int     chan;
    longint data;
  } res_t;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;
  logic enable   = 1'b0;

  avg_arb_sched_if #(.W(W), .N_CH(N_CH)) bus ();

  avg_arb_sched #(.W(W), .N_CH(N_CH), .N_AVG(N_AVG)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus.slave)
  );

  always #5 clock_in = ~clock_in;

  res_t   exp_q[$];
  longint samp [N_CH][$];
  int     last_g    = N_CH - 1;
  int     checks    = 0;
  int     errors    = 0;
  int     n_results = 0;
  int     last_chan = -1;
  longint last_data = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint block_avg(input longint s);
    longint t;
    t = s;
`ifdef AVG_ARB_SCHED_ROUND_EN
    t = t + N_AVG / 2;
`endif
    return floor_div(t, N_AVG);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    for (int c = 0; c < N_CH; c++) samp[c].delete();
    last_g = N_CH - 1;
  endfunction

  function automatic int model_grant();
    int c;
    if (reset || !enable) return -1;
    if (exp_q.size() != 0 && bus.out_ready !== 1'b1) return -1;
    for (int i = 1; i <= N_CH; i++) begin
      c = (last_g + i) % N_CH;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_ch(input int c, input longint v);
    bus.req_data[c*W +: W] = W'(v);
  endtask

  // Inputs are set at the negedge; grant checked before the edge, model advanced on it.
  task automatic step();
    int              g;
    logic [N_CH-1:0] ev;
    longint          s;
    #2;
    g = model_grant();
    if (!reset) begin
      ev = (g < 0) ? '0 : (N_CH'(1) << g);
      chk("req_ready", bus.req_ready, ev);
    end
    @(posedge clock_in);
    if (reset) begin
      model_reset();
    end else if (g >= 0) begin
      last_g = g;
      samp[g].push_back(longint'($signed(bus.req_data[g*W +: W])));
      if (samp[g].size() == N_AVG) begin
        s = 0;
        for (int k = 0; k < samp[g].size(); k++) s += samp[g][k];
        exp_q.push_back('{g, block_avg(s)});
        samp[g].delete();
      end
    end
    @(negedge clock_in);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    step();
    reset = 1'b0;
  endtask

  // Monitor: result must be present exactly when the model holds one, and match it.
  initial begin
    forever begin
      @(negedge clock_in);
      #3;
      if (!reset) begin
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          if (bus.out_valid === 1'b1) begin
            chk("out_chan", bus.out_chan, exp_q[0].chan);
            chk("out_data", longint'($signed(bus.out_data)), exp_q[0].data);
          end
          if (bus.out_ready === 1'b1) begin
            last_chan = int'(bus.out_chan);
            last_data = longint'($signed(bus.out_data));
            n_results++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    reset         = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_chan",  bus.out_chan,  0);
    chk("rst_out_data",  bus.out_data,  0);
    enable        = 1'b1;
    bus.out_ready = 1'b1;

    // Channel 0 alone: 10,20,30,40 -> 25
    n0 = n_results;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 10 * (i + 1));
      bus.req_valid = 4'b0001;
      step();
    end
    bus.req_valid = '0;
    repeat (2) step();
    chk("ch0_count", n_results - n0, 1);
    chk("ch0_chan",  last_chan, 0);
    chk("ch0_data",  last_data, 25);

    // All channels requesting: strict rotation
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N_CH; c++) set_ch(c, $urandom_range(0, 200));
      step();
    end

    // Negative values on channel 2
    do_reset();
    bus.req_valid = 4'b0100;
    set_ch(2, -1); step();
    step();
    step();
    set_ch(2, -2); step();
    bus.req_valid = '0;
    repeat (2) step();
    chk("neg_chan", last_chan, 2);
`ifdef AVG_ARB_SCHED_ROUND_EN
    chk("neg_data", last_data, -1);
`else
    chk("neg_data", last_data, -2);
`endif

    // Pending result with out_ready low stalls all grants
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      set_ch(3, $urandom_range(0, 1000));
      step();
    end
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ready", bus.req_ready, 0);
    end
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Held result discarded by reset
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    repeat (4) step();
    do_reset();
    chk("rst_hold_valid", bus.out_valid, 0);

    // Reset after three samples on channel 1
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0010;
    set_ch(1, 100);
    repeat (3) step();
    do_reset();
    chk("rst_mid_valid", bus.out_valid, 0);
    n0 = n_results;
    bus.req_valid = 4'b0010;
    set_ch(1, 8);
    repeat (4) step();
    bus.req_valid = '0;
    repeat (2) step();
    chk("rst_mid_count", n_results - n0, 1);
    chk("rst_mid_data",  last_data, 8);

    // Enable low freezes grants; rotation resumes where it stopped
    do_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < N_CH; c++) set_ch(c, 5 * c);
    repeat (2) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (6) step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.req_valid = N_CH'($urandom);
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 3) == 0) set_ch(c, longint'($urandom));
        else                           set_ch(c, longint'($urandom_range(0, 2000)) - 1000);
      end
      step();
    end

    reset         = 1'b0;
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    repeat (3) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_arb_sched.md
AVG_ARB_SCHED -- requirements
Module: avg_arb_sched

Interface
REQ-001 The block SHALL take parameter W, default 28, as the sample and result width in bits (signed).
REQ-002 The block SHALL take parameter N_CH, default 4, as the number of requesting channels; legal range 2..8.
REQ-003 The block SHALL take parameter N_AVG, default 1024, as the samples averaged per result; it SHALL be a power of two, at least 2.
REQ-004 clock_in  input  1  clock; all logic SHALL be on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  while low, no sample SHALL be accepted; state SHALL hold.
REQ-007 req_valid  input  N_CH  per-channel sample-valid.
REQ-008 req_data  input  N_CH*W  per-channel signed samples; channel k occupies bits [k*W+W-1:k*W].
REQ-009 req_ready  output  N_CH  one-hot grant; a sample transfers when req_valid[k] and req_ready[k] are both high.
REQ-010 out_valid  output  1  an averaged result is held.
REQ-011 out_ready  input  1  downstream accept; a result transfers when out_valid and out_ready are both high.
REQ-012 out_chan  output  clog2(N_CH)  channel index of the held result.
REQ-013 out_data  output  W  signed averaged result.

Function
REQ-014 req_ready SHALL be combinational from req_valid, the round-robin pointer, enable and the stall condition, with at most one bit high.
REQ-015 Arbitration SHALL be round-robin: search starts at the channel after the last granted channel and wraps from N_CH-1 to 0.
REQ-016 The pointer SHALL update only on a completed transfer, and SHALL not move while no channel is requesting.
REQ-017 Each channel SHALL own an accumulator of W+log2(N_AVG) bits and a count of log2(N_AVG) bits; a transfer SHALL add the sign-extended sample and increment that channel's count.
REQ-018 The transfer that is channel k's N_AVG-th sample SHALL load out_data with (acc[k]+sample) arithmetically shifted right by log2(N_AVG), set out_chan=k and out_valid=1 in the next cycle (latency 1), and clear acc[k] and count[k].
REQ-019 Stall: while out_valid=1 and out_ready=0, all req_ready bits SHALL be 0.
REQ-020 If out_valid=1 and out_ready=1 in the same cycle, that cycle SHALL be non-stalled. A transfer that completes a block in that cycle SHALL reload out_* with out_valid staying 1. Otherwise out_valid SHALL drop to 0.
REQ-021 The control FSM SHALL have states IDLE (no request), ACCUM (transfer this cycle) and HOLD (result pending, out_ready low). IDLE/ACCUM to HOLD on block completion. HOLD to ACCUM or IDLE on out_ready.
REQ-022 Accumulator overflow SHALL be impossible by width; no saturation logic.
REQ-023 enable low SHALL force req_ready to 0 but SHALL NOT clear a held result; out_ready is honoured regardless of enable.

Reset
REQ-024 On reset the block SHALL clear all accumulators and counts, set the pointer so channel 0 has first priority, and set out_valid=0, out_chan=0, out_data=0, FSM=IDLE.
REQ-025 Reset mid-block SHALL discard partial sums and any held result; the first result after reset SHALL need N_AVG fresh samples.

Configuration
REQ-026 With macro AVG_ARB_SCHED_ROUND_EN defined, the block SHALL add N_AVG/2 before the shift (round half up). Without it, the block SHALL truncate toward negative infinity.

Structure
REQ-027 Package avg_arb_pkg SHALL hold the W default, the log2/clog2 function and the FSM state enum.
REQ-028 Round-robin selection SHALL be sub-module rr_arbiter (inputs req, pointer; output one-hot grant). Accumulation and FSM stay in avg_arb_sched.

Verification
REQ-029 Verification SHALL use N_AVG=4 and N_CH=4.
REQ-030 Channel 0 alone sends 10,20,30,40 -> one result, out_chan=0, out_data=25, latency 1 cycle.
REQ-031 All four channels valid continuously -> grants cycle 0,1,2,3,0... with exactly one req_ready high per cycle.
REQ-032 Channel 2 sends -1,-1,-1,-2 -> out_data=-2 without the rounding macro and -1 with it.
REQ-033 Result pending with out_ready held low for 5 cycles -> req_ready stays 0 for those cycles, out_* stable. Raising out_ready resumes grants in the same cycle.
REQ-034 Reset asserted after 3 samples on channel 1 -> out_valid=0. The next 4 samples of 8 give out_data=8.
REQ-035 enable low for 3 cycles with all channels valid -> no transfers, counts unchanged, round-robin order resumes where it stopped.
